// File: rtl/usb_tx_pkt_sched.sv
// rtl/usb_tx_pkt_sched.sv - UTMI transmit packet scheduler: handshake/data arbitration, PID/payload/CRC16 sequencing, inter-packet gap
// Byte-wide reflected CRC16 (0xA001) update helper plus the scheduler top.

module usb_tx_crc16_upd (
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 16'hA001;
      else      c = c >> 1;
    end
    crc_out = c;
  end
endmodule

module usb_tx_pkt_sched #(
  parameter int MAX_LEN    = 64,
  parameter int IPG_CYCLES = 32,
  parameter int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_en,
  input  logic          hs_req,
  input  logic [3:0]    hs_pid,
  output logic          hs_done,
  input  logic          dat_req,
  input  logic [3:0]    dat_pid,
  input  logic [LW-1:0] dat_len,
  input  logic [7:0]    dat_byte,
  output logic          dat_rd,
  output logic          dat_done,
  output logic [7:0]    data_in,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy
);
  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_in_q, data_in_d;
  logic          tx_valid_q, tx_valid_d;
  logic          is_hs_q, is_hs_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   crc_upd;
  logic [3:0]    grant_pid;
  logic          accept;

  // CRC always covers the byte currently presented, so it advances only when that byte is taken.
  usb_tx_crc16_upd u_crc (
    .crc_in  (crc_q),
    .byte_in (data_in_q),
    .crc_out (crc_upd)
  );

  assign accept    = tx_valid_q & tx_ready;
  assign grant_pid = hs_req ? hs_pid : dat_pid;
  assign data_in   = data_in_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    data_in_d  = data_in_q;
    tx_valid_d = tx_valid_q;
    is_hs_d    = is_hs_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    crc_d      = crc_q;
    dat_rd     = 1'b0;
    hs_done    = 1'b0;
    dat_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_en && (hs_req || dat_req)) begin
          is_hs_d    = hs_req;
          len_d      = hs_req ? '0 : ((dat_len > MAX_LEN_L) ? MAX_LEN_L : dat_len);
          cnt_d      = '0;
          crc_d      = 16'hFFFF;
          data_in_d  = {~grant_pid, grant_pid};
          tx_valid_d = 1'b1;
          state_d    = S_PID;
        end
      end
      S_PID: begin
        if (accept) begin
          if (is_hs_q) begin
            tx_valid_d = 1'b0;
            gap_d      = GAP_LOAD;
            state_d    = S_GAP;
          end else if (len_q != '0) begin
            data_in_d = dat_byte;
            dat_rd    = 1'b1;
            cnt_d     = LW'(1);
            state_d   = S_DATA;
          end else begin
            data_in_d = ~crc_q[7:0];
            state_d   = S_CRC_LO;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          crc_d = crc_upd;
          if (cnt_q < len_q) begin
            data_in_d = dat_byte;
            dat_rd    = 1'b1;
            cnt_d     = cnt_q + LW'(1);
          end else begin
            data_in_d = ~crc_upd[7:0];
            state_d   = S_CRC_LO;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          data_in_d = ~crc_q[15:8];
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          gap_d      = GAP_LOAD;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        // Done fires in the last gap cycle so the requester drops its request before IDLE samples it.
        if (gap_q == '0) begin
          hs_done  = is_hs_q;
          dat_done = ~is_hs_q;
          state_d  = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_in_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      is_hs_q    <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      crc_q      <= 16'hFFFF;
    end else begin
      state_q    <= state_d;
      data_in_q  <= data_in_d;
      tx_valid_q <= tx_valid_d;
      is_hs_q    <= is_hs_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      crc_q      <= crc_d;
    end
  end
endmodule

// File: tb/tb_usb_tx_pkt_sched.sv
// tb/tb_usb_tx_pkt_sched.sv - scoreboard bench for usb_tx_pkt_sched with a queue-based packet reference model

module tb_usb_tx_pkt_sched;
  localparam int MAX_LEN = 64;
  localparam int IPG     = 32;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    bit         rd;
    bit         last;
    bit         is_hs;
  } exp_t;

  logic          clk, rst, tx_en;
  logic          hs_req, hs_done, dat_req, dat_rd, dat_done;
  logic [3:0]    hs_pid, dat_pid;
  logic [LW-1:0] dat_len;
  logic [7:0]    dat_byte, data_in;
  logic          tx_valid, tx_ready, busy;

  usb_tx_pkt_sched #(.MAX_LEN(MAX_LEN), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len),
    .dat_byte(dat_byte), .dat_rd(dat_rd), .dat_done(dat_done),
    .data_in(data_in), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  int   n_checks, n_fail;
  exp_t exp_q[$];
  bit   done_exp[$];
  logic [7:0] pay_q[$];
  bq_t  pl_a;
  bit   rd_flag, bg_done;
  int   ready_mode, tick;
  int   acc_cnt, rd_cnt, hs_done_cnt, dat_done_cnt;
  int   cyc, last_valid_cyc, last_done_cyc;
  bit   prev_valid, have_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_ev(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference CRC: one bit at a time, LSB first, straight from the polynomial definition.
  function automatic logic [15:0] crc_bits(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c = crc;
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ b[k]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic bq_t rand_pl(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic push_pkt(input bit is_hs, input logic [3:0] pid, input bq_t pl);
    exp_t e;
    logic [15:0] crc = 16'hFFFF;
    int n = pl.size();
    e.is_hs = is_hs;
    e.data  = {~pid, pid};
    e.rd    = !is_hs && (n > 0);
    e.last  = is_hs;
    exp_q.push_back(e);
    if (!is_hs) begin
      for (int i = 0; i < n; i++) begin
        e.data = pl[i];
        e.rd   = (i < n - 1);
        exp_q.push_back(e);
        crc = crc_bits(crc, pl[i]);
        pay_q.push_back(pl[i]);
      end
      e.rd   = 1'b0;
      e.data = ~crc[7:0];
      exp_q.push_back(e);
      e.data = ~crc[15:8];
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit do_hs, input logic [3:0] hpid, input bit do_dat,
                       input logic [3:0] dpid, input int len, input bq_t pl);
    int hs0, dt0, rd0;
    if (do_hs)  push_pkt(1'b1, hpid, pl);
    if (do_dat) push_pkt(1'b0, dpid, pl);
    hs0 = hs_done_cnt; dt0 = dat_done_cnt; rd0 = rd_cnt;
    hs_pid  = hpid;
    dat_pid = dpid;
    dat_len = LW'(len);
    hs_req  = do_hs;
    dat_req = do_dat;
    for (int c = 0; c < 8000 && (hs_req || dat_req); c++) begin
      step();
      if (hs_req && hs_done_cnt != hs0)  hs_req = 1'b0;
      if (dat_req && dat_done_cnt != dt0) dat_req = 1'b0;
    end
    if (hs_req || dat_req) fail_ev("issue_timeout", 0, 1);
    hs_req = 1'b0;
    dat_req = 1'b0;
    chk("dat_rd_count", rd_cnt - rd0, do_dat ? pl.size() : 0);
  endtask

  task automatic wait_bg();
    for (int c = 0; c < 9000 && !bg_done; c++) step();
    if (!bg_done) fail_ev("bg_timeout", 0, 1);
  endtask

  // tx_ready generation and the first-word-fall-through payload source
  initial begin
    tx_ready = 1'b0;
    dat_byte = 8'h00;
    forever begin
      logic [7:0] tmp;
      @(posedge clk);
      #1;
      tick++;
      if (rd_flag) begin
        if (pay_q.size() > 0) tmp = pay_q.pop_front();
        rd_flag = 1'b0;
      end
      dat_byte = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
      case (ready_mode)
        0:       tx_ready = 1'($urandom_range(0, 1));
        1:       tx_ready = (tick % 40 == 0);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // monitor: pops the scoreboard on every accepted byte and every done pulse
  initial begin
    exp_t e;
    bit t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_valid = 1'b0;
        have_done  = 1'b0;
      end else begin
        if (tx_valid && !prev_valid && have_done)
          chk("grant_after_done", (cyc - last_done_cyc) >= 2, 1);
        if (tx_valid && tx_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) fail_ev("unexpected_byte", data_in, -1);
          else begin
            e = exp_q.pop_front();
            chk("data_in", data_in, e.data);
            chk("dat_rd", dat_rd, e.rd);
            if (e.last) done_exp.push_back(e.is_hs);
          end
        end else if (dat_rd) fail_ev("dat_rd_no_accept", 1, 0);
        if (dat_rd) begin
          rd_flag = 1'b1;
          rd_cnt++;
        end
        if (tx_valid) last_valid_cyc = cyc;
        if (hs_done || dat_done) begin
          chk("done_onehot", hs_done && dat_done, 0);
          if (done_exp.size() == 0) fail_ev("unexpected_done", 1, 0);
          else begin
            t = done_exp.pop_front();
            chk("done_type_hs", hs_done, t);
            chk("ipg_cycles", cyc - last_valid_cyc, IPG);
          end
          last_done_cyc = cyc;
          have_done = 1'b1;
          if (hs_done) hs_done_cnt++;
          else         dat_done_cnt++;
        end
        prev_valid = tx_valid;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, vcount, bcount, mode, len;
    bq_t empty_pl;
    rst = 1'b1; tx_en = 1'b1;
    hs_req = 1'b0; hs_pid = 4'h0; dat_req = 1'b0; dat_pid = 4'h0; dat_len = '0;
    ready_mode = 2;
    repeat (3) step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_dat_rd", dat_rd, 0);
    chk("rst_hs_done", hs_done, 0);
    chk("rst_dat_done", dat_done, 0);
    rst = 1'b0;
    repeat (2) step();

    // ACK handshake with tx_ready only every 40 cycles
    ready_mode = 1;
    issue(1'b1, 4'h2, 1'b0, 4'h0, 0, empty_pl);

    // zero-length DATA1
    ready_mode = 0;
    issue(1'b0, 4'h0, 1'b1, 4'h3, 0, empty_pl);

    // CRC check vector "123456789" as DATA1 (PID 0xB)
    pl_a = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    issue(1'b0, 4'h0, 1'b1, 4'hB, 9, pl_a);

    // simultaneous requests: handshake goes first
    pl_a = rand_pl(5);
    issue(1'b1, 4'hA, 1'b1, 4'h3, 5, pl_a);

    // tx_en low holds off both pending requests
    tx_en = 1'b0;
    pl_a = rand_pl(4);
    bg_done = 1'b0;
    fork
      begin issue(1'b1, 4'hE, 1'b1, 4'hB, 4, pl_a); bg_done = 1'b1; end
    join_none
    vcount = 0; bcount = 0;
    repeat (100) begin
      step();
      if (tx_valid) vcount++;
      if (busy) bcount++;
    end
    chk("txen_hold_valid", vcount, 0);
    chk("txen_hold_busy", bcount, 0);
    tx_en = 1'b1;
    step();
    chk("txen_grant", tx_valid, 1);
    wait_bg();

    // tx_en dropped mid-packet does not abort it
    ready_mode = 0;
    pl_a = rand_pl(20);
    a0 = acc_cnt;
    bg_done = 1'b0;
    fork
      begin issue(1'b0, 4'h0, 1'b1, 4'h3, 20, pl_a); bg_done = 1'b1; end
    join_none
    for (int c = 0; c < 2000 && acc_cnt < a0 + 3; c++) step();
    tx_en = 1'b0;
    wait_bg();
    tx_en = 1'b1;

    // oversize length clamps to MAX_LEN
    ready_mode = 2;
    pl_a = rand_pl(MAX_LEN);
    issue(1'b0, 4'h0, 1'b1, 4'hB, 100, pl_a);

    // async reset while in DATA at byte 5
    pl_a = rand_pl(9);
    push_pkt(1'b0, 4'h3, pl_a);
    a0 = acc_cnt; d0 = dat_done_cnt;
    dat_pid = 4'h3; dat_len = LW'(9); dat_req = 1'b1;
    for (int c = 0; c < 500 && (acc_cnt - a0) < 5; c++) step();
    chk("rst_reached_byte5", acc_cnt - a0, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete(); done_exp.delete(); pay_q.delete();
    rd_flag = 1'b0; dat_req = 1'b0; dat_len = '0;
    step(); step();
    rst = 1'b0;
    repeat (40) step();
    chk("rst_no_done", dat_done_cnt - d0, 0);
    pl_a = rand_pl(3);
    issue(1'b0, 4'h0, 1'b1, 4'hB, 3, pl_a);

    // randomized traffic
    for (int it = 0; it < 12; it++) begin
      mode = $urandom_range(0, 2);
      len  = $urandom_range(0, 70);
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      pl_a = (mode == 0) ? empty_pl : rand_pl((len > MAX_LEN) ? MAX_LEN : len);
      issue(mode != 1, 4'($urandom), mode != 0, 4'($urandom), len, pl_a);
    end

    repeat (5) step();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_exp_empty", done_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_tx_pkt_sched.md
Name: usb_tx_pkt_sched

Overview:
Packet-level transmit scheduler in front of the UTMI transmit port (data_in / tx_valid / tx_ready) of the UTM tx block. It arbitrates between a handshake requester (ACK/NAK/STALL) and a data-packet requester. For the granted request it sequences PID byte, payload bytes and CRC16 onto the UTMI byte interface. After each packet it enforces an inter-packet gap before the next grant.

Parameters:
MAX_LEN, 64, maximum payload bytes per data packet; LW = clog2(MAX_LEN+1).
IPG_CYCLES, 32, clk cycles from tx_valid deassertion to next grant (covers EOP, tx_oen tail and bus turnaround; clk = 4x FS bit rate).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tx_en  in  1  permits new grants (low while suspended / op_mode not normal); does not abort an active packet
hs_req  in  1  handshake request, held until hs_done
hs_pid  in  4  handshake PID
hs_done  out  1  one-cycle pulse: handshake packet finished
dat_req  in  1  data packet request, held until dat_done
dat_pid  in  4  data PID (DATA0/DATA1/...)
dat_len  in  LW  payload length, 0..MAX_LEN
dat_byte  in  8  payload byte, first-word-fall-through
dat_rd  out  1  pop strobe for dat_byte
dat_done  out  1  one-cycle pulse: data packet finished
data_in  out  8  UTMI transmit byte
tx_valid  out  1  UTMI transmit valid
tx_ready  in  1  UTMI: byte on data_in accepted this cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE. data_in=0x00. tx_valid, dat_rd, hs_done, dat_done, busy = 0. CRC = 0xFFFF. Counters = 0.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- IDLE: grant only when tx_en=1. Priority hs_req > dat_req, fixed and non-preemptive.
- On grant: latch PID and length (length > MAX_LEN clamped to MAX_LEN). Next edge: data_in={~pid,pid}, tx_valid=1, enter PID.
- Byte transfer rule: a byte is consumed on each cycle with tx_valid=1 and tx_ready=1. data_in changes only on the edge after such a cycle and is stable otherwise.
- PID on accept:
  - handshake: tx_valid<=0, go to GAP.
  - data with len>0: data_in<=dat_byte, dat_rd=1 (same cycle), byte count=1, go to DATA.
  - data with len=0: data_in<=~CRC[7:0], go to CRC_LO.
- DATA on accept: CRC updated with the accepted byte.
  - count<len: load next dat_byte, pulse dat_rd, count+1.
  - count=len: data_in<=~CRCnext[7:0], go to CRC_LO.
- CRC_LO on accept: data_in<=~CRC[15:8], go to CRC_HI.
- CRC_HI on accept: tx_valid<=0, go to GAP.
- CRC16: poly 0x8005 reflected (0xA001), init 0xFFFF, bytes processed LSB first. Transmitted complemented, low byte first. CRC re-initialised on every grant.
- dat_rd: exactly len pulses per data packet, only on accept cycles. No pops for handshakes or len=0.
- GAP: counter loads IPG_CYCLES-1 on entry and counts down to 0. At 0, pulse hs_done or dat_done (matching the granted requester) and go to IDLE. A new grant is possible on the following cycle.
- dat_req, hs_req or tx_en changing mid-packet: ignored until IDLE.
- tx_ready while tx_valid=0: ignored.
- Async reset mid-packet: immediately tx_valid=0 and IDLE, with no done pulse.

Test Plan:
- hs_req, hs_pid=0x2, tx_ready pulsed every 40 cycles -> data_in=0xD2, tx_valid drops the edge after the accept; hs_done pulses exactly IPG_CYCLES cycles after tx_valid falls; dat_rd never asserts.
- dat_req, dat_pid=0x3, dat_len=0 -> byte sequence 0xC3, 0x00, 0x00; dat_done pulses once; zero dat_rd pulses.
- dat_pid=0xB, payload "123456789" (0x31..0x39), len=9 -> 0x4B, 0x31..0x39, 0xC8, 0xB4; exactly 9 dat_rd pulses, each coincident with an accept.
- hs_req and dat_req rise in the same cycle -> handshake sent first; data packet grant occurs no earlier than the cycle after hs_done.
- tx_en=0 with both requests pending -> tx_valid stays 0 for 100 cycles; tx_en=1 -> grant within 1 cycle. tx_en dropped mid-data-packet -> packet completes normally.
- rst asserted while in DATA at byte 5 -> tx_valid=0, busy=0 asynchronously, no done pulse; after release, a new len=3 request sends a correct full packet with re-initialised CRC.
